// File: rtl/ring_output_arbiter.sv
// Round-robin arbiter sharing one router output among four requesters, each with a one-flit holding buffer.
// Define ARB_POLARITY_EN to forward only flits whose VC bit (DW-1) matches the current cycle polarity.
module ring_output_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_si,
  input  logic [NREQ*DW-1:0]  req_di,
  output logic [NREQ-1:0]     req_ri,
  input  logic                out_ro,
  output logic                out_so,
  output logic [DW-1:0]       out_do,
  output logic [1:0]          grant_idx,
  output logic                polarity_out
);

  logic [NREQ-1:0] full_q, full_d;
  logic [DW-1:0]   buf_q [NREQ];
  logic [DW-1:0]   buf_d [NREQ];
  logic [1:0]      rr_q, rr_d;
  logic            out_so_q, out_so_d;
  logic [DW-1:0]   out_do_q, out_do_d;
  logic [1:0]      grant_idx_q, grant_idx_d;
  logic            polarity_q, polarity_d;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      scan_idx;
  logic            grant_fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
`ifdef ARB_POLARITY_EN
      elig[i] = full_q[i] && (buf_q[i][DW-1] == polarity_q);
`else
      elig[i] = full_q[i];
`endif
    end
  end

  // First eligible requester scanning from the round-robin pointer upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = rr_q + 2'(k);
      if (!win_found && elig[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign grant_fire = out_ro && win_found;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      full_d[i] = full_q[i];
      buf_d[i]  = buf_q[i];
      if (req_si[i] && !full_q[i]) begin
        full_d[i] = 1'b1;
        buf_d[i]  = req_di[i*DW +: DW];
      end
      // A granted buffer was full, so a same-edge strobe is never loaded above.
      if (grant_fire && (win_idx == 2'(i))) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    out_so_d    = 1'b0;
    out_do_d    = '0;
    grant_idx_d = grant_idx_q;
    if (grant_fire) begin
      rr_d        = win_idx + 2'd1;
      out_so_d    = 1'b1;
      out_do_d    = buf_q[win_idx];
      grant_idx_d = win_idx;
    end
    polarity_d = ~polarity_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q      <= '0;
      for (int i = 0; i < NREQ; i++) buf_q[i] <= '0;
      rr_q        <= 2'd0;
      out_so_q    <= 1'b0;
      out_do_q    <= '0;
      grant_idx_q <= 2'd0;
      polarity_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      for (int i = 0; i < NREQ; i++) buf_q[i] <= buf_d[i];
      rr_q        <= rr_d;
      out_so_q    <= out_so_d;
      out_do_q    <= out_do_d;
      grant_idx_q <= grant_idx_d;
      polarity_q  <= polarity_d;
    end
  end

  assign req_ri       = ~full_q;
  assign out_so       = out_so_q;
  assign out_do       = out_do_q;
  assign grant_idx    = grant_idx_q;
  assign polarity_out = polarity_q;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Directed self-checking bench for ring_output_arbiter; polarity-specific steps follow ARB_POLARITY_EN.
module tb_ring_output_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_si = 4'b0;
  logic [63:0]  d [4];
  logic [255:0] req_di;
  logic [3:0]   req_ri;
  logic         out_ro = 1'b1;
  logic         out_so;
  logic [63:0]  out_do;
  logic [1:0]   grant_idx;
  logic         polarity_out;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_pol = 1'b0;

  assign req_di = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  ring_output_arbiter #(.NREQ(4), .DW(64)) dut (
    .clk(clk), .reset(reset), .req_si(req_si), .req_di(req_di), .req_ri(req_ri),
    .out_ro(out_ro), .out_so(out_so), .out_do(out_do), .grant_idx(grant_idx),
    .polarity_out(polarity_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_pol = ~exp_pol;
    chk("polarity", 64'(polarity_out), 64'(exp_pol));
  endtask

  task automatic chk_out(input string tag, input logic so, input logic [63:0] dat, input logic [1:0] g);
    chk({tag, "_so"}, 64'(out_so), 64'(so));
    chk({tag, "_do"}, out_do, dat);
    chk({tag, "_gi"}, 64'(grant_idx), 64'(g));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 64'h0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_so", 64'(out_so), 64'd0);
    chk("rst_do", out_do, 64'd0);
    chk("rst_ri", 64'(req_ri), 64'hF);
    chk("rst_pol", 64'(polarity_out), 64'd0);
    reset = 1'b1;
    exp_pol = 1'b0;
    #2;
    chk("rel_pol", 64'(polarity_out), 64'd0);
    step();

`ifndef ARB_POLARITY_EN
    // Round robin: all four load on the same edge, rr starts at 0
    d[0] = 64'h11; d[1] = 64'h22; d[2] = 64'h33; d[3] = 64'h44;
    req_si = 4'b1111;
    step();
    req_si = 4'b0000;
    chk("rr_load_ri", 64'(req_ri), 64'h0);
    chk_out("rr_load", 1'b0, 64'h0, 2'd0);
    step(); chk_out("rr0", 1'b1, 64'h11, 2'd0); chk("rr0_ri", 64'(req_ri), 64'h1);
    step(); chk_out("rr1", 1'b1, 64'h22, 2'd1); chk("rr1_ri", 64'(req_ri), 64'h3);
    step(); chk_out("rr2", 1'b1, 64'h33, 2'd2);
    step(); chk_out("rr3", 1'b1, 64'h44, 2'd3); chk("rr3_ri", 64'(req_ri), 64'hF);
    step(); chk_out("rr_idle", 1'b0, 64'h0, 2'd3);

    // Pointer wrapped to 0: requester 0 beats requester 3
    d[0] = 64'hA0; d[3] = 64'hA3;
    req_si = 4'b1001;
    step();
    req_si = 4'b0000;
    step(); chk_out("wrap0", 1'b1, 64'hA0, 2'd0);
    step(); chk_out("wrap3", 1'b1, 64'hA3, 2'd3);
    step(); chk_out("wrap_idle", 1'b0, 64'h0, 2'd3);
`endif

    // Single requester, VC 0: align so the grant edge sees polarity 0
    if (exp_pol != 1'b1) step();
    d[0] = 64'h200200000000FA50;
    req_si = 4'b0001;
    step();
    req_si = 4'b0000;
    chk("single_ri_busy", 64'(req_ri[0]), 64'd0);
    chk("single_so_early", 64'(out_so), 64'd0);
    step();
    chk_out("single", 1'b1, 64'h200200000000FA50, 2'd0);
    chk("single_ri_free", 64'(req_ri[0]), 64'd1);
    step();
    chk_out("single_idle", 1'b0, 64'h0, 2'd0);

    // Stall: requester 2 held while out_ro low for 5 cycles
    out_ro = 1'b0;
    d[2] = 64'hABCDEF;
    req_si = 4'b0100;
    step();
    req_si = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      chk("stall_so", 64'(out_so), 64'd0);
      chk("stall_ri2", 64'(req_ri[2]), 64'd0);
      if (c < 4) step();
    end
    if (exp_pol != 1'b0) begin
      step();
      chk("stall_so_x", 64'(out_so), 64'd0);
    end
    out_ro = 1'b1;
    step();
    chk_out("stall_release", 1'b1, 64'hABCDEF, 2'd2);
    chk("stall_ri2_free", 64'(req_ri[2]), 64'd1);
    step();
    chk_out("stall_idle", 1'b0, 64'h0, 2'd2);

`ifdef ARB_POLARITY_EN
    // VC1 flit in requester 1 and VC0 flit in requester 3, loaded while polarity is 0
    if (exp_pol != 1'b0) step();
    d[1] = 64'h8000000000000001; d[3] = 64'h3;
    req_si = 4'b1010;
    step();
    req_si = 4'b0000;
    chk_out("pol_load", 1'b0, 64'h0, 2'd2);
    step(); chk_out("pol_vc1", 1'b1, 64'h8000000000000001, 2'd1);
    step(); chk_out("pol_vc0", 1'b1, 64'h3, 2'd3);
    step(); chk_out("pol_idle", 1'b0, 64'h0, 2'd3);
`endif

    // Mid-operation reset with every buffer full
    out_ro = 1'b0;
    d[0] = 64'hD0; d[1] = 64'hD1; d[2] = 64'hD2; d[3] = 64'hD3;
    req_si = 4'b1111;
    step();
    req_si = 4'b0000;
    chk("mid_full_ri", 64'(req_ri), 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ri", 64'(req_ri), 64'hF);
    chk("mid_rst_so", 64'(out_so), 64'd0);
    chk("mid_rst_pol", 64'(polarity_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pol = 1'b0;
    out_ro = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_so", 64'(out_so), 64'd0);
      chk("post_rst_ri", 64'(req_ri), 64'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
